// File: rtl/gnn_0_save_multi.sv
// gnn_0_save_multi: streams a run of beats from one of N_CH feature buffers to DRAM
// over an AXI4 write master. Bursts are capped at MAX_BURST and split at 4 KB lines.
// Buffer reads are credit-limited so the beat FIFO can never overflow.
module gnn_0_save_multi #(
    parameter int N_CH       = 4,
    parameter int DATA_W     = 512,
    parameter int ADDR_W     = 64,
    parameter int BUF_ADDR_W = 11,
    parameter int RD_LATENCY = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BURST  = 16,
    parameter int MAX_OUTST  = 8,
    parameter int INST_W     = 128
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     ap_start,
    output logic                     ap_done,
    output logic                     err,
    input  logic [ADDR_W-1:0]        ctrl_addr_offset,
    input  logic [INST_W-1:0]        ctrl_instruction,
    output logic                     m_axi_awvalid,
    input  logic                     m_axi_awready,
    output logic [ADDR_W-1:0]        m_axi_awaddr,
    output logic [7:0]               m_axi_awlen,
    output logic                     m_axi_wvalid,
    input  logic                     m_axi_wready,
    output logic [DATA_W-1:0]        m_axi_wdata,
    output logic [DATA_W/8-1:0]      m_axi_wstrb,
    output logic                     m_axi_wlast,
    input  logic                     m_axi_bvalid,
    output logic                     m_axi_bready,
    output logic [N_CH-1:0]          buf_rd_addr_valid,
    output logic [BUF_ADDR_W-1:0]    buf_rd_addr,
    input  logic [N_CH-1:0]          buf_rd_data_valid,
    input  logic [N_CH*DATA_W-1:0]   buf_rd_data
);
    localparam int BYTES = DATA_W / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int FAW   = $clog2(FIFO_DEPTH);
    localparam int CW    = FAW + 1;
    localparam int OW    = $clog2(MAX_OUTST + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT_B, S_DONE} state_t;
    state_t state;

    // instruction fields
    logic [31:0]           inst_dram;
    logic [15:0]           inst_len;
    logic [BUF_ADDR_W-1:0] inst_buf;
    logic [7:0]            inst_ch;
    logic                  unused_inst;
    assign inst_dram   = ctrl_instruction[127:96];
    assign inst_len    = ctrl_instruction[95:80];
    assign inst_buf    = ctrl_instruction[64 +: BUF_ADDR_W];
    assign inst_ch     = ctrl_instruction[63:56];
    assign unused_inst = ^{ctrl_instruction[INST_W-1:128], ctrl_instruction[79:64+BUF_ADDR_W],
                           ctrl_instruction[55:0]};

    logic              ch_ok, cmd_ok, launch;
    logic [ADDR_W-1:0] start_addr;
    assign ch_ok      = int'(inst_ch) < N_CH;
    assign cmd_ok     = ch_ok && (inst_len != 16'd0);
    assign launch     = (state == S_IDLE) && ap_start && cmd_ok;
    assign start_addr = ctrl_addr_offset + (ADDR_W'(inst_dram) << BSH);

    // beats in the burst starting at addr: min(remaining, MAX_BURST, beats to 4 KB line)
    function automatic logic [15:0] burst_len(input logic [ADDR_W-1:0] addr, input logic [15:0] rem);
        logic [12:0] to4k;
        logic [15:0] bl;
        to4k = (13'd4096 - {1'b0, addr[11:0]} + 13'(BYTES - 1)) >> BSH;
        bl   = rem;
        if (bl > 16'(MAX_BURST)) bl = 16'(MAX_BURST);
        if (bl > 16'(to4k))      bl = 16'(to4k);
        return bl;
    endfunction

    // shared state
    logic [7:0]            ch_q;
    logic [ADDR_W-1:0]     aw_next_addr, w_addr;
    logic [15:0]           aw_remain, aw_cov, rd_remain, w_remain, w_beat, w_sent;
    logic [BUF_ADDR_W-1:0] rd_next;
    logic [CW-1:0]         used, in_flight, occ;
    logic [OW-1:0]         outst;
    logic [FAW-1:0]        wptr, rptr;
    logic [DATA_W-1:0]     fifo_mem [FIFO_DEPTH];

    // AW issue decision
    logic [ADDR_W-1:0] aw_cur_addr;
    logic [15:0]       aw_cur_rem, aw_bl;
    logic              aw_issue, aw_hs, b_hs;
    assign aw_cur_addr = launch ? start_addr : aw_next_addr;
    assign aw_cur_rem  = launch ? inst_len : aw_remain;
    assign aw_bl       = burst_len(aw_cur_addr, aw_cur_rem);
    assign aw_issue    = launch || (state == S_RUN && !m_axi_awvalid && aw_remain != 16'd0 &&
                                    outst < OW'(MAX_OUTST));
    assign aw_hs       = m_axi_awvalid && m_axi_awready;
    assign b_hs        = m_axi_bvalid && m_axi_bready;

    // read issue decision; 'used' = beats requested but not yet popped on W
    logic                  rd_issue;
    logic [7:0]            ch_cur;
    logic [BUF_ADDR_W-1:0] rd_cur;
    logic [N_CH-1:0]       ch_oh;
    assign rd_issue = launch || (state == S_RUN && rd_remain != 16'd0 && used < CW'(FIFO_DEPTH));
    assign ch_cur   = launch ? inst_ch : ch_q;
    assign rd_cur   = launch ? inst_buf : rd_next;

    // returns from the selected channel only; stale returns with nothing in flight are dropped
    logic              ret_v, push;
    logic [DATA_W-1:0] ret_d;
    always_comb begin
        ret_v = 1'b0;
        ret_d = '0;
        ch_oh = '0;
        for (int k = 0; k < N_CH; k++) begin
            ch_oh[k] = (ch_cur == 8'(k));
            if (ch_q == 8'(k)) begin
                ret_v = buf_rd_data_valid[k];
                ret_d = buf_rd_data[k*DATA_W +: DATA_W];
            end
        end
    end
    assign push = ret_v && (in_flight != '0) && (state != S_IDLE);

    // W path: only beats already covered by an accepted AW may go out
    logic [15:0] w_bl;
    logic        w_last_i, w_hs;
    assign w_bl         = burst_len(w_addr, w_remain);
    assign w_last_i     = (w_beat == w_bl - 16'd1);
    assign m_axi_wvalid = (state == S_RUN) && (occ != '0) && (w_sent < aw_cov);
    assign m_axi_wdata  = m_axi_wvalid ? fifo_mem[rptr] : '0;
    assign m_axi_wstrb  = {(DATA_W/8){m_axi_wvalid}};
    assign m_axi_wlast  = m_axi_wvalid && w_last_i;
    assign w_hs         = m_axi_wvalid && m_axi_wready;
    assign m_axi_bready = (state == S_RUN) || (state == S_WAIT_B);

    // control FSM with registered done/err pulse
    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            state   <= S_IDLE;
            ap_done <= 1'b0;
            err     <= 1'b0;
            ch_q    <= '0;
        end else begin
            ap_done <= 1'b0;
            err     <= 1'b0;
            case (state)
                S_IDLE: if (ap_start) begin
                    ch_q <= inst_ch;
                    if (cmd_ok) state <= S_RUN;
                    else begin
                        state   <= S_DONE;
                        ap_done <= 1'b1;
                        err     <= !ch_ok;
                    end
                end
                S_RUN:    if (w_hs && w_last_i && w_remain == w_bl) state <= S_WAIT_B;
                S_WAIT_B: if (outst == '0) begin
                    state   <= S_DONE;
                    ap_done <= 1'b1;
                end
                default:  state <= S_IDLE;
            endcase
        end
    end

    // AW issuer: one burst at a time, held stable until accepted
    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            m_axi_awvalid <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awlen   <= '0;
            aw_next_addr  <= '0;
            aw_remain     <= '0;
            aw_cov        <= '0;
        end else begin
            if (aw_hs) begin
                m_axi_awvalid <= 1'b0;
                aw_cov        <= aw_cov + 16'(m_axi_awlen) + 16'd1;
            end
            if (aw_issue) begin
                m_axi_awvalid <= 1'b1;
                m_axi_awaddr  <= aw_cur_addr;
                m_axi_awlen   <= 8'(aw_bl - 16'd1);
                aw_next_addr  <= aw_cur_addr + (ADDR_W'(aw_bl) << BSH);
                aw_remain     <= aw_cur_rem - aw_bl;
            end
            if (launch) aw_cov <= '0;
        end
    end

    // buffer read issuer and credit counters
    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            buf_rd_addr_valid <= '0;
            buf_rd_addr       <= '0;
            rd_next           <= '0;
            rd_remain         <= '0;
            used              <= '0;
            in_flight         <= '0;
        end else begin
            buf_rd_addr_valid <= rd_issue ? ch_oh : '0;
            if (rd_issue) begin
                buf_rd_addr <= rd_cur;
                rd_next     <= rd_cur + 1'b1;
                rd_remain   <= (launch ? inst_len : rd_remain) - 16'd1;
            end
            used      <= used + CW'(rd_issue) - CW'(w_hs);
            in_flight <= in_flight + CW'(rd_issue) - CW'(push);
        end
    end

    // beat FIFO pointers and occupancy
    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (w_hs) rptr <= rptr + 1'b1;
            occ <= occ + CW'(push) - CW'(w_hs);
        end
    end

    // beat FIFO storage
    always_ff @(posedge aclk) begin
        if (push) fifo_mem[wptr] <= ret_d;
    end

    // W burst tracker: re-derives each burst length to place wlast
    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            w_addr   <= '0;
            w_remain <= '0;
            w_beat   <= '0;
            w_sent   <= '0;
        end else if (launch) begin
            w_addr   <= start_addr;
            w_remain <= inst_len;
            w_beat   <= '0;
            w_sent   <= '0;
        end else if (w_hs) begin
            w_sent <= w_sent + 16'd1;
            if (w_last_i) begin
                w_addr   <= w_addr + (ADDR_W'(w_bl) << BSH);
                w_remain <= w_remain - w_bl;
                w_beat   <= '0;
            end else begin
                w_beat <= w_beat + 16'd1;
            end
        end
    end

    // outstanding bursts awaiting B
    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) outst <= '0;
        else case ({aw_hs, b_hs})
            2'b10:   outst <= outst + 1'b1;
            2'b01:   outst <= outst - 1'b1;
            default: outst <= outst;
        endcase
    end
endmodule

// File: tb/tb_gnn_0_save_multi.sv
// Bench for gnn_0_save_multi: directed commands push expected AW/W/read/done items into
// queues; a negedge monitor pops and compares whatever the DUT presents.
`timescale 1ns/1ps
module tb_gnn_0_save_multi;
    localparam int N_CH = 4, DATA_W = 512, ADDR_W = 64, BUF_ADDR_W = 11, RD_LATENCY = 3;
    localparam int FIFO_DEPTH = 16, MAX_BURST = 16, MAX_OUTST = 8, INST_W = 128;

    logic aclk = 1'b0;
    logic areset, ap_start, ap_done, err;
    logic [ADDR_W-1:0] ctrl_addr_offset;
    logic [INST_W-1:0] ctrl_instruction;
    logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_wlast;
    logic m_axi_bvalid = 1'b0;
    logic m_axi_bready;
    logic [ADDR_W-1:0] m_axi_awaddr;
    logic [7:0] m_axi_awlen;
    logic [DATA_W-1:0] m_axi_wdata;
    logic [DATA_W/8-1:0] m_axi_wstrb;
    logic [N_CH-1:0] buf_rd_addr_valid, buf_rd_data_valid;
    logic [BUF_ADDR_W-1:0] buf_rd_addr;
    logic [N_CH*DATA_W-1:0] buf_rd_data;

    gnn_0_save_multi #(.N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BUF_ADDR_W(BUF_ADDR_W),
        .RD_LATENCY(RD_LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .MAX_BURST(MAX_BURST),
        .MAX_OUTST(MAX_OUTST), .INST_W(INST_W)) dut (
        .aclk(aclk), .areset(areset), .ap_start(ap_start), .ap_done(ap_done), .err(err),
        .ctrl_addr_offset(ctrl_addr_offset), .ctrl_instruction(ctrl_instruction),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awlen(m_axi_awlen), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .buf_rd_addr_valid(buf_rd_addr_valid), .buf_rd_addr(buf_rd_addr),
        .buf_rd_data_valid(buf_rd_data_valid), .buf_rd_data(buf_rd_data));

    always #5 aclk = ~aclk;

    typedef struct { logic [ADDR_W-1:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [DATA_W-1:0] data; logic last; } w_t;
    typedef struct { logic [N_CH-1:0] oh; logic [BUF_ADDR_W-1:0] addr; } rd_t;
    typedef struct { logic err; int nb; } dn_t;
    aw_t exp_aw[$];
    w_t  exp_w[$];
    rd_t exp_rd[$];
    dn_t exp_dn[$];
    aw_t ea;
    w_t  ew;
    rd_t er;
    dn_t ed;

    int n_vec = 0, n_err = 0;
    int done_cnt = 0, b_seen = 0, b_owed = 0, rd_issued = 0, w_popped = 0, aw_beats = 0;
    int cur_ch = 0;
    logic noise_en = 1'b0;

    function automatic logic [DATA_W-1:0] mk_data(input int ch, input int a);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W/32; i++) r[i*32 +: 32] = {8'(ch), 8'(i), 5'd0, 11'(a)};
        return r;
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    // buffer model: fixed read latency; random noise valids on unselected channels
    logic [N_CH-1:0] bv_pipe [RD_LATENCY];
    logic [BUF_ADDR_W-1:0] ba_pipe [RD_LATENCY];
    logic [N_CH-1:0] noise = '0;
    initial for (int i = 0; i < RD_LATENCY; i++) begin bv_pipe[i] = '0; ba_pipe[i] = '0; end
    always @(posedge aclk) begin
        bv_pipe[0] <= buf_rd_addr_valid;
        ba_pipe[0] <= buf_rd_addr;
        for (int i = 1; i < RD_LATENCY; i++) begin
            bv_pipe[i] <= bv_pipe[i-1];
            ba_pipe[i] <= ba_pipe[i-1];
        end
        noise <= noise_en ? (4'($urandom) & ~(4'b1 << cur_ch)) : '0;
    end
    always_comb begin
        buf_rd_data_valid = bv_pipe[RD_LATENCY-1] | noise;
        buf_rd_data = '0;
        for (int k = 0; k < N_CH; k++) buf_rd_data[k*DATA_W +: DATA_W] = mk_data(k, int'(ba_pipe[RD_LATENCY-1]));
    end

    // B responder: one response per completed W burst
    always @(posedge aclk) begin
        #1;
        m_axi_bvalid = areset && (b_owed > 0);
    end

    // monitor: compares every presented output against the scoreboard
    always @(negedge aclk) begin
        if (!areset) begin
            exp_aw.delete(); exp_w.delete(); exp_rd.delete(); exp_dn.delete();
            b_owed = 0; b_seen = 0; rd_issued = 0; w_popped = 0; aw_beats = 0;
        end else begin
            if (m_axi_awvalid && m_axi_awready) begin
                aw_beats += int'(m_axi_awlen) + 1;
                if (exp_aw.size() == 0) flag("aw unexpected burst");
                else begin
                    ea = exp_aw.pop_front();
                    check("awaddr", m_axi_awaddr, ea.addr);
                    check("awlen", m_axi_awlen, ea.len);
                end
            end
            if (buf_rd_addr_valid != '0) begin
                rd_issued++;
                if (exp_rd.size() == 0) flag("rd unexpected request");
                else begin
                    er = exp_rd.pop_front();
                    check("rd_addr", {buf_rd_addr_valid, buf_rd_addr}, {er.oh, er.addr});
                end
            end
            if (m_axi_wvalid && m_axi_wready) begin
                if (w_popped >= aw_beats) flag("w beat ahead of its AW");
                w_popped++;
                if (m_axi_wlast) b_owed++;
                if (exp_w.size() == 0) flag("w unexpected beat");
                else begin
                    ew = exp_w.pop_front();
                    check("wdata", m_axi_wdata, ew.data);
                    check("wlast", m_axi_wlast, ew.last);
                end
            end
            if (rd_issued - w_popped > FIFO_DEPTH) flag("fifo overflow: requests exceed depth");
            if (m_axi_bvalid && m_axi_bready) begin b_owed--; b_seen++; end
            if (err && !ap_done) flag("err without ap_done");
            if (ap_done) begin
                if (exp_dn.size() == 0) flag("ap_done unexpected");
                else begin
                    ed = exp_dn.pop_front();
                    check("err", err, ed.err);
                    check("b_count", b_seen, ed.nb);
                end
                b_seen = 0;
                done_cnt++;
            end
        end
    end

    // push expected traffic for one command
    task automatic model_push(input int ch, input int len, input int bs, input int dram,
                              input logic [ADDR_W-1:0] off);
        logic [ADDR_W-1:0] addr;
        int rem, to4k, bl, beat, nb;
        if (ch >= N_CH || len == 0) begin
            exp_dn.push_back('{err: (ch >= N_CH), nb: 0});
            return;
        end
        for (int i = 0; i < len; i++)
            exp_rd.push_back('{oh: N_CH'(1) << ch, addr: BUF_ADDR_W'(bs + i)});
        addr = off + ADDR_W'(dram) * 64;
        rem = len; beat = 0; nb = 0;
        while (rem > 0) begin
            to4k = (4096 - int'(addr[11:0])) / 64;
            bl = rem;
            if (bl > MAX_BURST) bl = MAX_BURST;
            if (bl > to4k) bl = to4k;
            exp_aw.push_back('{addr: addr, len: 8'(bl - 1)});
            for (int j = 0; j < bl; j++) begin
                exp_w.push_back('{data: mk_data(ch, (bs + beat) % 2048), last: (j == bl - 1)});
                beat++;
            end
            addr += ADDR_W'(bl) * 64;
            rem -= bl;
            nb++;
        end
        exp_dn.push_back('{err: 1'b0, nb: nb});
    endtask

    task automatic start_cmd(input int ch, input int len, input int bs, input int dram,
                             input logic [ADDR_W-1:0] off);
        cur_ch = ch;
        model_push(ch, len, bs, dram, off);
        @(posedge aclk); #1;
        ctrl_instruction = {32'(dram), 16'(len), 16'(bs), 8'(ch), 56'd0};
        ctrl_addr_offset = off;
        ap_start = 1'b1;
        @(posedge aclk); #1;
        ap_start = 1'b0;
        if (ch < N_CH && len != 0) begin
            check("first_rd_latency", buf_rd_addr_valid != '0, 1);
            check("first_aw_latency", m_axi_awvalid, 1);
        end else begin
            check("done_latency", ap_done, 1);
            check("no_aw_on_reject", m_axi_awvalid, 0);
        end
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (done_cnt < target && t < 3000) begin @(posedge aclk); t++; end
        if (done_cnt < target) flag($sformatf("timeout waiting for done #%0d", target));
    endtask

    task automatic wait_beats(input int target);
        int t = 0;
        while (w_popped < target && t < 3000) begin @(posedge aclk); t++; end
        if (w_popped < target) flag("timeout waiting for W beats");
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_awvalid"}, m_axi_awvalid, 0);
        check({tag, "_wvalid"}, m_axi_wvalid, 0);
        check({tag, "_wlast"}, m_axi_wlast, 0);
        check({tag, "_bready"}, m_axi_bready, 0);
        check({tag, "_rdvalid"}, buf_rd_addr_valid, 0);
        check({tag, "_done_err"}, {ap_done, err}, 0);
    endtask

    int base;
    initial begin
        areset = 1'b0; ap_start = 1'b0; m_axi_awready = 1'b1; m_axi_wready = 1'b1;
        ctrl_instruction = '0; ctrl_addr_offset = '0;
        repeat (3) @(posedge aclk);
        #1 check_idle_outputs("reset");
        @(posedge aclk); #1 areset = 1'b1;
        repeat (2) @(posedge aclk);

        // single full burst from channel 1
        start_cmd(1, 16, 'h010, 0, 64'h8000_0000);
        wait_done(1);
        noise_en = 1'b1;

        // 4 KB split: 0xF00 -> 4 beats, then 6 beats at 0x1000
        start_cmd(2, 10, 'h100, 60, 64'h0);
        wait_done(2);

        // three bursts 16/16/8 with a 20-cycle wready stall mid-transfer
        base = w_popped;
        start_cmd(0, 40, 'h200, 'h100, 64'h1_0000_0000);
        wait_beats(base + 8);
        @(posedge aclk); #1 m_axi_wready = 1'b0;
        repeat (20) @(posedge aclk);
        #1 check("stall_fill_depth", rd_issued - w_popped, FIFO_DEPTH);
        m_axi_wready = 1'b1;
        wait_done(3);

        // bad channel and zero length
        start_cmd(5, 4, 0, 0, 64'h0);
        wait_done(4);
        start_cmd(1, 0, 0, 0, 64'h0);
        wait_done(5);

        // ap_start while running must be ignored
        start_cmd(3, 20, 'h300, 'h200, 64'h0);
        repeat (4) @(posedge aclk);
        #1 ctrl_instruction = {32'd0, 16'd4, 16'd0, 8'd7, 56'd0};
        ap_start = 1'b1;
        @(posedge aclk); #1 ap_start = 1'b0;
        wait_done(6);
        repeat (6) @(posedge aclk);
        check("no_extra_done", done_cnt, 6);

        // buffer address wrap
        start_cmd(3, 4, 'h7FE, 'h10, 64'h0);
        wait_done(7);

        // reset mid-burst, then a clean command
        base = w_popped;
        start_cmd(2, 32, 'h400, 0, 64'h0);
        wait_beats(base + 5);
        @(posedge aclk); #1 areset = 1'b0;
        #1 check_idle_outputs("midreset");
        repeat (3) @(posedge aclk);
        #1 areset = 1'b1;
        repeat (10) @(posedge aclk);
        start_cmd(1, 16, 'h010, 0, 64'h8000_0000);
        wait_done(8);

        repeat (5) @(posedge aclk);
        check("aw_left", exp_aw.size(), 0);
        check("w_left", exp_w.size(), 0);
        check("rd_left", exp_rd.size(), 0);
        check("done_left", exp_dn.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
